// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in serial-out transmitter for the single-bit serial link.
// Latency: first bit on SER_OUT the cycle after the accepting edge; one bit per CLK after that.
// Backpressure: LOAD_READY is high in IDLE and during the final bit of a frame; otherwise low.
//
// Optional build macro: PARITY_EN appends one even-parity bit to each frame (WIDTH+1 cycles).
//
// Ports:
//   CLK, RST       clock and synchronous active-high reset
//   DATA_IN        parallel word, sampled when LOAD_VALID && LOAD_READY
//   LOAD_VALID     source has a word on DATA_IN
//   LOAD_READY     serializer accepts a word this cycle
//   SER_OUT        serial data bit (idles high)
//   SER_VALID      SER_OUT carries a frame bit
//   FRAME_START    first bit of a frame
//   FRAME_END      last bit of a frame (parity bit when PARITY_EN)
//   BUSY           a frame is in progress
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter int MSB_FIRST = 0
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] DATA_IN,
   input  logic             LOAD_VALID,
   output logic             LOAD_READY,
   output logic             SER_OUT,
   output logic             SER_VALID,
   output logic             FRAME_START,
   output logic             FRAME_END,
   output logic             BUSY
);

   localparam int CW = $clog2(WIDTH);

`ifdef PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   logic parity_q, parity_n;
`else
   typedef enum logic {IDLE, SHIFT} state_t;
`endif

   state_t           state_q, state_n;
   logic [WIDTH-1:0] shreg_q, shreg_n, shifted;
   logic [CW-1:0]    cnt_q, cnt_n;
   logic             accept, begin_frame, first_bit, next_bit;
   logic             ready_n, ser_n, valid_n, start_n, end_n, busy_n;

   always_comb begin
      accept      = LOAD_VALID && LOAD_READY;
      shifted     = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);
      first_bit   = (MSB_FIRST != 0) ? DATA_IN[WIDTH-1] : DATA_IN[0];
      next_bit    = (MSB_FIRST != 0) ? shifted[WIDTH-1] : shifted[0];

      state_n     = state_q;
      shreg_n     = shreg_q;
      cnt_n       = cnt_q;
      begin_frame = 1'b0;
      ready_n     = 1'b1;
      ser_n       = 1'b1;
      valid_n     = 1'b0;
      start_n     = 1'b0;
      end_n       = 1'b0;
      busy_n      = 1'b0;
`ifdef PARITY_EN
      parity_n    = parity_q;
`endif

      case (state_q)
         IDLE: begin
            begin_frame = accept;
         end
         SHIFT: begin
            if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef PARITY_EN
               // Parity cycle carries FRAME_END and opens the load window.
               state_n = PARITY;
               cnt_n   = '0;
               ser_n   = parity_q;
               valid_n = 1'b1;
               busy_n  = 1'b1;
               end_n   = 1'b1;
               ready_n = 1'b1;
`else
               // Final data bit: chain straight into a new word if one is offered.
               begin_frame = accept;
               state_n     = IDLE;
               cnt_n       = '0;
`endif
            end else begin
               shreg_n = shifted;
               cnt_n   = cnt_q + 1'b1;
               ser_n   = next_bit;
               valid_n = 1'b1;
               busy_n  = 1'b1;
`ifdef PARITY_EN
               ready_n = 1'b0;
`else
               // Next cycle is the final data bit: it ends the frame and accepts a word.
               end_n   = (cnt_q == CW'(WIDTH - 2));
               ready_n = (cnt_q == CW'(WIDTH - 2));
`endif
            end
         end
`ifdef PARITY_EN
         PARITY: begin
            begin_frame = accept;
            state_n     = IDLE;
         end
`endif
         default: begin
            state_n = IDLE;
         end
      endcase

      if (begin_frame) begin
         state_n = SHIFT;
         shreg_n = DATA_IN;
         cnt_n   = '0;
         ser_n   = first_bit;
         valid_n = 1'b1;
         start_n = 1'b1;
         busy_n  = 1'b1;
         ready_n = 1'b0;
         end_n   = 1'b0;
`ifdef PARITY_EN
         parity_n = ^DATA_IN;
`endif
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= IDLE;
         shreg_q     <= '0;
         cnt_q       <= '0;
         LOAD_READY  <= 1'b1;
         SER_OUT     <= 1'b1;
         SER_VALID   <= 1'b0;
         FRAME_START <= 1'b0;
         FRAME_END   <= 1'b0;
         BUSY        <= 1'b0;
`ifdef PARITY_EN
         parity_q    <= 1'b0;
`endif
      end else begin
         state_q     <= state_n;
         shreg_q     <= shreg_n;
         cnt_q       <= cnt_n;
         LOAD_READY  <= ready_n;
         SER_OUT     <= ser_n;
         SER_VALID   <= valid_n;
         FRAME_START <= start_n;
         FRAME_END   <= end_n;
         BUSY        <= busy_n;
`ifdef PARITY_EN
         parity_q    <= parity_n;
`endif
      end
   end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (LSB-first and MSB-first, WIDTH=8).
// Expected serial bits are hand-written in send order and queued before each load;
// per-instance monitors pop and compare on every SER_VALID cycle.
module tb_piso_serializer;

   typedef struct packed {
      logic ser;
      logic fs;
      logic fe;
   } exp_t;

`ifdef PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic       clk;
   logic       rst;
   logic [7:0] data_in, data_m;
   logic       load_valid, valid_m;
   logic       load_ready, ser_out, ser_valid, frame_start, frame_end, busy;
   logic       ready_m, ser_m, svalid_m, fstart_m, fend_m, busy_m;

   exp_t q[$];
   exp_t qm[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   piso_serializer #(.WIDTH(8), .MSB_FIRST(0)) dut (
      .CLK(clk), .RST(rst), .DATA_IN(data_in), .LOAD_VALID(load_valid),
      .LOAD_READY(load_ready), .SER_OUT(ser_out), .SER_VALID(ser_valid),
      .FRAME_START(frame_start), .FRAME_END(frame_end), .BUSY(busy)
   );

   piso_serializer #(.WIDTH(8), .MSB_FIRST(1)) dut_m (
      .CLK(clk), .RST(rst), .DATA_IN(data_m), .LOAD_VALID(valid_m),
      .LOAD_READY(ready_m), .SER_OUT(ser_m), .SER_VALID(svalid_m),
      .FRAME_START(fstart_m), .FRAME_END(fend_m), .BUSY(busy_m)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // seq is written in send order: seq[0] goes out first.
   task automatic push_frame(input int which, input logic [0:7] seq, input logic par,
                             input int nbits);
      exp_t e;
      for (int i = 0; i < nbits; i++) begin
         e.ser = seq[i];
         e.fs  = (i == 0);
`ifdef PARITY_EN
         e.fe  = 1'b0;
`else
         e.fe  = (i == 7);
`endif
         if (which == 0) q.push_back(e); else qm.push_back(e);
      end
`ifdef PARITY_EN
      if (nbits == 8) begin
         e.ser = par; e.fs = 1'b0; e.fe = 1'b1;
         if (which == 0) q.push_back(e); else qm.push_back(e);
      end
`else
      e.ser = par;
`endif
   endtask

   task automatic send(input logic [7:0] d);
      bit ok;
      data_in    = d;
      load_valid = 1'b1;
      ok = 0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (load_ready) ok = 1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL send_timeout: LOAD_READY never high, got 0 expected 1");
      end
      @(posedge clk);
      #1 load_valid = 1'b0;
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (!busy) ok = 1;
      end
      if (!ok) begin
         n_cmp++; n_bad++;
         $display("FAIL idle_timeout: BUSY stuck, got 1 expected 0");
      end
   endtask

   // Monitors: compare every presented bit against the scoreboard.
   always @(negedge clk) begin
      if (ser_valid) begin
         if (q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL lsb_unexpected_bit: got ser=%b fs=%b fe=%b, expected no bit",
                     ser_out, frame_start, frame_end);
         end else begin
            exp_t e;
            e = q.pop_front();
            check("lsb_bit {ser,fs,fe}", {5'd0, ser_out, frame_start, frame_end},
                  {5'd0, e.ser, e.fs, e.fe});
         end
      end else if (!rst) begin
         check("lsb_idle_strobes {fs,fe}", {6'd0, frame_start, frame_end}, 8'd0);
      end
   end

   always @(negedge clk) begin
      if (svalid_m) begin
         if (qm.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL msb_unexpected_bit: got ser=%b fs=%b fe=%b, expected no bit",
                     ser_m, fstart_m, fend_m);
         end else begin
            exp_t e;
            e = qm.pop_front();
            check("msb_bit {ser,fs,fe}", {5'd0, ser_m, fstart_m, fend_m},
                  {5'd0, e.ser, e.fs, e.fe});
         end
      end
   end

   initial begin
      bit drained;
      rst        = 1'b1;
      load_valid = 1'b1;
      data_in    = 8'hFF;
      valid_m    = 1'b0;
      data_m     = 8'h00;

      // Reset held two edges with LOAD_VALID high: nothing may be accepted.
      repeat (2) @(posedge clk);
      #1 rst = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      check("rst_load_ready", {7'd0, load_ready}, 8'd1);
      check("rst_ser_out",    {7'd0, ser_out},    8'd1);
      check("rst_ser_valid",  {7'd0, ser_valid},  8'd0);
      check("rst_busy",       {7'd0, busy},       8'd0);
      check("rst_strobes",    {6'd0, frame_start, frame_end}, 8'd0);
      repeat (3) @(negedge clk);
      check("rst_no_accept", {7'd0, ser_valid}, 8'd0);

      // Single frame A5, LSB first.
      @(posedge clk); #1;
      push_frame(0, 8'b10100101, 1'b0, 8);
      send(8'hA5);
      @(negedge clk);
      check("first_bit_busy", {7'd0, busy}, 8'd1);
      wait_idle();
      check("idle_ser_out",    {7'd0, ser_out},    8'd1);
      check("idle_load_ready", {7'd0, load_ready}, 8'd1);

      // Back-to-back 3C then C3: SER_VALID must stay high across both frames.
      @(posedge clk); #1;
      push_frame(0, 8'b00111100, 1'b0, 8);
      push_frame(0, 8'b11000011, 1'b0, 8);
      send(8'h3C);
      fork
         send(8'hC3);
         begin
            for (int i = 0; i < 2 * FL; i++) begin
               @(negedge clk);
               check("b2b_continuous_valid", {7'd0, ser_valid}, 8'd1);
            end
         end
      join
      wait_idle();

      // Busy rejection: FF offered mid-frame must not disturb the A5 frame.
      @(posedge clk); #1;
      push_frame(0, 8'b10100101, 1'b0, 8);
      send(8'hA5);
      @(posedge clk);
      @(posedge clk); #1;
      data_in = 8'hFF; load_valid = 1'b1;
      @(negedge clk);
      check("busy_reject_ready", {7'd0, load_ready}, 8'd0);
      @(posedge clk); #1;
      @(negedge clk);
      check("busy_reject_ready2", {7'd0, load_ready}, 8'd0);
      @(posedge clk); #1 load_valid = 1'b0;
      wait_idle();

      // Reset mid-frame after three bits of F0, then 01 must serialize cleanly.
      @(posedge clk); #1;
      push_frame(0, 8'b00001111, 1'b0, 3);
      send(8'hF0);
      @(posedge clk);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      check("midrst_ser_valid", {7'd0, ser_valid}, 8'd0);
      check("midrst_ser_out",   {7'd0, ser_out},   8'd1);
      check("midrst_busy",      {7'd0, busy},      8'd0);
      check("midrst_frame_end", {7'd0, frame_end}, 8'd0);
      @(posedge clk); #1;
      push_frame(0, 8'b10000000, 1'b1, 8);
      send(8'h01);
      wait_idle();

      // Reset and handshake on the same edge: the word is dropped.
      @(posedge clk); #1 rst = 1'b1; load_valid = 1'b1; data_in = 8'h55;
      @(posedge clk); #1 rst = 1'b0; load_valid = 1'b0;
      @(negedge clk);
      check("rst_wins_valid", {7'd0, ser_valid},  8'd0);
      check("rst_wins_ready", {7'd0, load_ready}, 8'd1);

      // 07 (parity 1 when enabled) on the LSB-first instance, 80 on the MSB-first one.
      @(posedge clk); #1;
      push_frame(0, 8'b11100000, 1'b1, 8);
      push_frame(1, 8'b10000000, 1'b1, 8);
      data_m = 8'h80; valid_m = 1'b1;
      fork
         send(8'h07);
         begin
            @(posedge clk); #1 valid_m = 1'b0;
         end
      join
      wait_idle();

      drained = 0;
      for (int i = 0; i < 50 && !drained; i++) begin
         @(negedge clk);
         if (q.size() == 0 && qm.size() == 0) drained = 1;
      end
      check("lsb_queue_drained", q.size() > 255 ? 8'hFF : 8'(q.size()), 8'd0);
      check("msb_queue_drained", qm.size() > 255 ? 8'hFF : 8'(qm.size()), 8'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
